// File: rtl/vga_pkg.sv
// Shared VGA pixel-source types and defaults: RGB333 colour type, bounce-axis
// state and the helpers used to update the box position and rotate its colour.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

  typedef logic [8:0] rgb333_t;

  localparam rgb333_t RGB_BLACK  = 9'h000;
  localparam rgb333_t FG_DEFAULT = 9'h1C0;
  localparam rgb333_t BG_DEFAULT = 9'h007;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

  typedef struct packed {
    logic [9:0] pos;
    dir_t       dir;
    logic       rev;
  } axis_t;

  // One bounce step on a single axis; 11-bit signed so a negative step is visible.
  function automatic axis_t axis_next(input logic [9:0]        pos,
                                      input dir_t              dir,
                                      input logic signed [10:0] step,
                                      input logic signed [10:0] limit);
    axis_t             r;
    logic signed [10:0] nx;
    r.pos = pos;
    r.dir = dir;
    r.rev = 1'b0;
    if (dir == DIR_POS) begin
      nx = $signed({1'b0, pos}) + step;
      if (nx >= limit) begin
        r.pos = limit[9:0];
        r.dir = DIR_NEG;
        r.rev = 1'b1;
      end else begin
        r.pos = nx[9:0];
      end
    end else begin
      nx = $signed({1'b0, pos}) - step;
      if (nx <= 11'sd0) begin
        r.pos = '0;
        r.dir = DIR_POS;
        r.rev = 1'b1;
      end else begin
        r.pos = nx[9:0];
      end
    end
    return r;
  endfunction

  // Channel rotation: k=1 rotates left by 3 bits, k=2 by 6 bits.
  function automatic rgb333_t rgb_rotl(input rgb333_t c, input logic [1:0] k);
    case (k)
      2'd1:    return {c[5:0], c[8:6]};
      2'd2:    return {c[2:0], c[8:3]};
      default: return c;
    endcase
  endfunction

endpackage

// File: rtl/vga_frame_tick.sv
// Vsync falling-edge detector followed by a FRAME_DIV divider; upd_tick pulses
// for one cycle on every FRAME_DIV-th frame start.
module vga_frame_tick
  import vga_pkg::*;
#(
  parameter int unsigned FRAME_DIV = 1
) (
  input  logic clk25,
  input  logic rst_n,
  input  logic vsync,
  output logic upd_tick
);

  localparam int unsigned CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic          vsync_q;
  logic [CW-1:0] frame_cnt;
  logic          tick;
  logic          wrap;

  assign tick     = vsync_q & ~vsync;
  assign wrap     = (frame_cnt == CW'(FRAME_DIV - 1));
  assign upd_tick = tick & wrap;

  // History resets high so releasing reset never fabricates an edge.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q   <= 1'b1;
      frame_cnt <= '0;
    end else begin
      vsync_q <= vsync;
      if (tick) begin
        frame_cnt <= wrap ? '0 : frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_bounce_sprite_gen.sv
// Bouncing-box pixel source feeding the VGA timing stage (RGB333 out, 1-cycle latency).
// Optional VGA_SPRITE_COLOR_CYCLE_EN rotates the box colour channels on every bounce.
module vga_bounce_sprite_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
  parameter int unsigned BOX_W     = 32,
  parameter int unsigned BOX_H     = 32,
  parameter int unsigned X_INIT    = 16,
  parameter int unsigned Y_INIT    = 16,
  parameter int unsigned STEP      = 2,
  parameter int unsigned FRAME_DIV = 1,
  parameter rgb333_t     FG_COLOR  = FG_DEFAULT,
  parameter rgb333_t     BG_COLOR  = BG_DEFAULT
) (
  input  logic          clk25,
  input  logic          rst_n,
  input  logic [9:0]    hcount,
  input  logic [9:0]    vcount,
  input  logic          video_on,
  input  logic          vsync,
  output logic [8:0]    pixel_data,
  output logic [9:0]    box_x,
  output logic [9:0]    box_y
);

  localparam logic signed [10:0] X_LIM  = 11'(H_ACTIVE - BOX_W);
  localparam logic signed [10:0] Y_LIM  = 11'(V_ACTIVE - BOX_H);
  localparam logic signed [10:0] STEP_S = 11'(STEP);

  logic    upd_tick;
  dir_t    dir_x;
  dir_t    dir_y;
  axis_t   ax;
  axis_t   ay;
  logic    in_box;
  rgb333_t box_color;

  vga_frame_tick #(
    .FRAME_DIV(FRAME_DIV)
  ) u_frame_tick (
    .clk25   (clk25),
    .rst_n   (rst_n),
    .vsync   (vsync),
    .upd_tick(upd_tick)
  );

  always_comb begin
    ax = axis_next(box_x, dir_x, STEP_S, X_LIM);
    ay = axis_next(box_y, dir_y, STEP_S, Y_LIM);
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      box_x <= 10'(X_INIT);
      box_y <= 10'(Y_INIT);
      dir_x <= DIR_POS;
      dir_y <= DIR_POS;
    end else if (upd_tick) begin
      box_x <= ax.pos;
      box_y <= ay.pos;
      dir_x <= ax.dir;
      dir_y <= ay.dir;
    end
  end

`ifdef VGA_SPRITE_COLOR_CYCLE_EN
  logic [2:0] color_idx;

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      color_idx <= '0;
    end else if (upd_tick && (ax.rev || ay.rev)) begin
      color_idx <= color_idx + 3'd1;
    end
  end

  always_comb begin
    box_color = rgb_rotl(FG_COLOR, 2'(color_idx % 3'd3));
  end
`else
  always_comb begin
    box_color = FG_COLOR;
  end
`endif

  // Compare in 11 bits so box_x+BOX_W cannot wrap at the right edge.
  always_comb begin
    in_box = ({1'b0, hcount} >= {1'b0, box_x}) &&
             ({1'b0, hcount} <  {1'b0, box_x} + 11'(BOX_W)) &&
             ({1'b0, vcount} >= {1'b0, box_y}) &&
             ({1'b0, vcount} <  {1'b0, box_y} + 11'(BOX_H));
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      pixel_data <= RGB_BLACK;
    end else if (!video_on) begin
      pixel_data <= RGB_BLACK;
    end else begin
      pixel_data <= in_box ? box_color : BG_COLOR;
    end
  end

endmodule

// File: tb/tb_vga_bounce_sprite_gen.sv
// Directed bench for vga_bounce_sprite_gen: reset, drawing, motion, bounce,
// corner and frame-divider behaviour across four parameterisations.
module tb_vga_bounce_sprite_gen;

  logic       clk25 = 1'b0;
  logic       rst_n;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       video_on;
  logic       vsync;

  logic [8:0] a_pix, b_pix, c_pix, d_pix;
  logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y, d_x, d_y;

  int errors = 0;
  int checks = 0;

  always #20 clk25 = ~clk25;

  vga_bounce_sprite_gen dut_a (
    .clk25(clk25), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
    .video_on(video_on), .vsync(vsync),
    .pixel_data(a_pix), .box_x(a_x), .box_y(a_y)
  );

  vga_bounce_sprite_gen #(.X_INIT(607)) dut_b (
    .clk25(clk25), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
    .video_on(video_on), .vsync(vsync),
    .pixel_data(b_pix), .box_x(b_x), .box_y(b_y)
  );

  vga_bounce_sprite_gen #(.H_ACTIVE(64), .V_ACTIVE(64), .X_INIT(31), .Y_INIT(31)) dut_c (
    .clk25(clk25), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
    .video_on(video_on), .vsync(vsync),
    .pixel_data(c_pix), .box_x(c_x), .box_y(c_y)
  );

  vga_bounce_sprite_gen #(.FRAME_DIV(4)) dut_d (
    .clk25(clk25), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
    .video_on(video_on), .vsync(vsync),
    .pixel_data(d_pix), .box_x(d_x), .box_y(d_y)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk25);
    #1;
  endtask

  task automatic do_reset();
    vsync    = 1'b1;
    video_on = 1'b0;
    hcount   = '0;
    vcount   = '0;
    rst_n    = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic vsync_pulse();
    vsync = 1'b0;
    step(2);
    vsync = 1'b1;
    step(2);
  endtask

  task automatic test_reset();
    do_reset();
    if (a_x !== 10'd16 || a_y !== 10'd16 || a_pix !== 9'h000) begin
      errors++;
      $display("FAIL reset_init: x=%0d y=%0d pix=%h, want 16 16 000", a_x, a_y, a_pix);
    end
    checks++;
    vsync_pulse();
    hcount = 10'd20; vcount = 10'd20; video_on = 1'b1;
    step(1);
    if (a_x !== 10'd18 || a_pix !== 9'h1C0) begin
      errors++;
      $display("FAIL reset_premove: x=%0d pix=%h, want 18 1C0", a_x, a_pix);
    end
    checks++;
    @(negedge clk25);
    #3 rst_n = 1'b0;
    #1;
    if (a_x !== 10'd16 || a_y !== 10'd16 || a_pix !== 9'h000) begin
      errors++;
      $display("FAIL reset_midline: x=%0d y=%0d pix=%h, want 16 16 000", a_x, a_y, a_pix);
    end
    checks++;
    step(1);
    rst_n = 1'b1;
    step(4);
    if (a_x !== 10'd16 || a_y !== 10'd16) begin
      errors++;
      $display("FAIL reset_release_notick: x=%0d y=%0d, want 16 16", a_x, a_y);
    end
    checks++;
  endtask

  task automatic test_draw();
    logic [9:0] hv [6];
    logic [9:0] vv [6];
    logic       ov [6];
    logic [8:0] ev [6];
    do_reset();
    hv = '{10'd16, 10'd47, 10'd48, 10'd15, 10'd20, 10'd16};
    vv = '{10'd16, 10'd47, 10'd16, 10'd16, 10'd48, 10'd16};
    ov = '{1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b0};
    ev = '{9'h1C0, 9'h1C0, 9'h007, 9'h007, 9'h007, 9'h000};
    for (int i = 0; i < 6; i++) begin
      hcount = hv[i]; vcount = vv[i]; video_on = ov[i];
      step(1);
      if (a_pix !== ev[i]) begin
        errors++;
        $display("FAIL draw_%0d: h=%0d v=%0d on=%b pix=%h, want %h",
                 i, hv[i], vv[i], ov[i], a_pix, ev[i]);
      end
      checks++;
    end
  endtask

  task automatic test_motion();
    do_reset();
    repeat (3) vsync_pulse();
    if (a_x !== 10'd22 || a_y !== 10'd22) begin
      errors++;
      $display("FAIL motion_3edges: x=%0d y=%0d, want 22 22", a_x, a_y);
    end
    checks++;
    vsync = 1'b0;
    step(10);
    if (a_x !== 10'd24 || a_y !== 10'd24) begin
      errors++;
      $display("FAIL motion_hold_low: x=%0d y=%0d, want 24 24", a_x, a_y);
    end
    checks++;
    vsync = 1'b1;
    step(10);
    if (a_x !== 10'd24 || a_y !== 10'd24) begin
      errors++;
      $display("FAIL motion_hold_high: x=%0d y=%0d, want 24 24", a_x, a_y);
    end
    checks++;
  endtask

  task automatic test_bounce();
    do_reset();
    if (b_x !== 10'd607) begin
      errors++;
      $display("FAIL bounce_init: x=%0d, want 607", b_x);
    end
    checks++;
    vsync_pulse();
    if (b_x !== 10'd608) begin
      errors++;
      $display("FAIL bounce_clamp: x=%0d, want 608", b_x);
    end
    checks++;
    vsync_pulse();
    if (b_x !== 10'd606) begin
      errors++;
      $display("FAIL bounce_reverse: x=%0d, want 606", b_x);
    end
    checks++;
  endtask

  task automatic test_corner();
    logic [8:0] exp_pix;
    do_reset();
    vsync_pulse();
    if (c_x !== 10'd32 || c_y !== 10'd32) begin
      errors++;
      $display("FAIL corner_far: x=%0d y=%0d, want 32 32", c_x, c_y);
    end
    checks++;
    repeat (15) vsync_pulse();
    if (c_x !== 10'd2 || c_y !== 10'd2) begin
      errors++;
      $display("FAIL corner_approach: x=%0d y=%0d, want 2 2", c_x, c_y);
    end
    checks++;
    vsync_pulse();
    if (c_x !== 10'd0 || c_y !== 10'd0) begin
      errors++;
      $display("FAIL corner_clamp: x=%0d y=%0d, want 0 0", c_x, c_y);
    end
    checks++;
`ifdef VGA_SPRITE_COLOR_CYCLE_EN
    exp_pix = 9'h038;
`else
    exp_pix = 9'h1C0;
`endif
    hcount = 10'd0; vcount = 10'd0; video_on = 1'b1;
    step(1);
    if (c_pix !== exp_pix) begin
      errors++;
      $display("FAIL corner_color: pix=%h, want %h", c_pix, exp_pix);
    end
    checks++;
    video_on = 1'b0;
    vsync_pulse();
    if (c_x !== 10'd2 || c_y !== 10'd2) begin
      errors++;
      $display("FAIL corner_rebound: x=%0d y=%0d, want 2 2", c_x, c_y);
    end
    checks++;
  endtask

  task automatic test_divider();
    logic [9:0] exp_x;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      vsync_pulse();
      exp_x = (i >= 8) ? 10'd20 : (i >= 4) ? 10'd18 : 10'd16;
      if (d_x !== exp_x || d_y !== exp_x) begin
        errors++;
        $display("FAIL divider_edge%0d: x=%0d y=%0d, want %0d", i, d_x, d_y, exp_x);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_draw();
    test_motion();
    test_bounce();
    test_corner();
    test_divider();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
